// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV32I multi-cycle control FSM (FETCH/DECODE/EXEC/MEM/WB) with bounded memory waits.
// Define PERF_CNT_EN to build the cycle and retired-instruction counters.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        reg_write_en,
  input  logic        branch_taken,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        rf_we,
  output logic        halt,
  output logic        fault,
  output logic [2:0]  state,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);
  typedef enum logic [2:0] {
    FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3,
    WB = 3'd4, HALT = 3'd5, FAULT = 3'd6
  } state_t;
  localparam logic [TO_W-1:0] TO_LIM = TO_W'(MEM_TIMEOUT - 1);
  state_t r_state, w_next;
  logic [TO_W-1:0] r_to;
  logic w_ld, w_st, w_br, w_jal, w_jalr, w_misc, w_sys, w_legal;
  logic w_wait, w_expire, w_pc_we;
  assign w_ld   = opcode == 7'b0000011;
  assign w_st   = opcode == 7'b0100011;
  assign w_br   = opcode == 7'b1100011;
  assign w_jal  = opcode == 7'b1101111;
  assign w_jalr = opcode == 7'b1100111;
  assign w_misc = opcode == 7'b0001111;
  assign w_sys  = opcode == 7'b1110011;
  assign w_legal = w_ld | w_st | w_br | w_jal | w_jalr | w_misc | w_sys |
                   opcode == 7'b0110111 | opcode == 7'b0010111 |
                   opcode == 7'b0010011 | opcode == 7'b0110011;
  // Only the request states ever wait; ready seen elsewhere has no effect.
  assign w_wait = (r_state == FETCH && !imem_ready) || (r_state == MEM && !dmem_ready);
  assign w_expire = (MEM_TIMEOUT != 0) && w_wait && r_to == TO_LIM;
  always_comb begin
    w_next = FETCH;
    case (r_state)
      FETCH:  w_next = imem_ready ? DECODE : w_expire ? FAULT : FETCH;
      DECODE: w_next = w_legal ? EXEC : FAULT;
      EXEC:   w_next = (w_ld || w_st) ? MEM : (w_br || w_misc) ? FETCH :
                       (w_sys && funct3 == 3'd0) ? HALT : WB;
      MEM:    w_next = dmem_ready ? (w_ld ? WB : FETCH) : w_expire ? FAULT : MEM;
      WB:     w_next = FETCH;
      HALT:   w_next = HALT;
      FAULT:  w_next = FAULT;
      default: w_next = FETCH;
    endcase
  end
  // Any non-waiting cycle clears the count, so FETCH and MEM are always entered at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= FETCH;
      r_to    <= '0;
    end else begin
      r_state <= w_next;
      r_to    <= w_wait ? r_to + 1'b1 : '0;
    end
  end
  assign w_pc_we = (r_state == EXEC && (w_br || w_misc)) ||
                   (r_state == MEM && dmem_ready && !w_ld) || r_state == WB;
  assign imem_req = rst_n && r_state == FETCH;
  assign ir_we    = rst_n && r_state == FETCH && imem_ready;
  assign dmem_req = rst_n && r_state == MEM;
  assign dmem_we  = rst_n && r_state == MEM && w_st;
  assign pc_we    = rst_n && w_pc_we;
  assign pc_sel   = !rst_n ? 2'd0 :
                    ((r_state == EXEC && w_br && branch_taken) || (r_state == WB && w_jal)) ? 2'd1 :
                    (r_state == WB && w_jalr) ? 2'd2 : 2'd0;
  assign rf_we    = rst_n && r_state == WB && reg_write_en;
  assign halt     = rst_n && r_state == HALT;
  assign fault    = rst_n && r_state == FAULT;
  assign state    = rst_n ? r_state : 3'd0;
`ifdef PERF_CNT_EN
  logic [31:0] r_cyc, r_ins;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cyc <= '0;
      r_ins <= '0;
    end else begin
      if (r_state != HALT && r_state != FAULT) r_cyc <= r_cyc + 32'd1;
      if (w_pc_we) r_ins <= r_ins + 32'd1;
    end
  end
  assign cycle_cnt   = rst_n ? r_cyc : '0;
  assign instret_cnt = rst_n ? r_ins : '0;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed checks of multicycle_ctrl with MEM_TIMEOUT=4.
module tb_multicycle_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic reg_write_en = 1'b0, branch_taken = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
  logic imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, halt, fault;
  logic [1:0] pc_sel;
  logic [2:0] state;
  logic [31:0] cycle_cnt, instret_cnt;
  logic [9:0] obs;
  int n_assert = 0, n_fail = 0;
  localparam logic [6:0] OPI = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011, BR = 7'b1100011,
                         JAL = 7'b1101111, JALR = 7'b1100111, SYS = 7'b1110011, BAD = 7'b0000000;
  localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4,
                         S_H = 3'd5, S_X = 3'd6;
  // obs bits: imem_req dmem_req dmem_we ir_we pc_we pc_sel[1:0] rf_we halt fault
  localparam logic [9:0] O_IDLE = 10'b0000000000, O_FET = 10'b1000000000, O_FETR = 10'b1001000000,
                         O_MEM = 10'b0100000000, O_STR = 10'b0110100000, O_WB = 10'b0000100100,
                         O_WBJR = 10'b0000110100, O_WBJ = 10'b0000101100, O_BRT = 10'b0000101000,
                         O_BRN = 10'b0000100000, O_HLT = 10'b0000000010, O_FLT = 10'b0000000001;
  assign obs = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rf_we, halt, fault};
  multicycle_ctrl #(.MEM_TIMEOUT(4), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .reg_write_en(reg_write_en),
    .branch_taken(branch_taken), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we), .pc_we(pc_we),
    .pc_sel(pc_sel), .rf_we(rf_we), .halt(halt), .fault(fault), .state(state),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );
  always #5 clk = ~clk;
  task automatic step(input string tag, input logic ir, input logic dr, input logic bt,
                      input logic [6:0] op, input logic [2:0] f3, input logic rw,
                      input logic [2:0] est, input logic [9:0] eo);
    imem_ready = ir; dmem_ready = dr; branch_taken = bt; opcode = op; funct3 = f3; reg_write_en = rw;
    #1;
    n_assert++;
    assert (state === est) else begin
      n_fail++;
      $error("FAIL %s state: observed %0d expected %0d", tag, state, est);
    end
    n_assert++;
    assert (obs === eo) else begin
      n_fail++;
      $error("FAIL %s strobes: observed %b expected %b", tag, obs, eo);
    end
    @(posedge clk); #1;
  endtask
  task automatic cnt(input string tag, input logic [31:0] c, input logic [31:0] i);
    logic [31:0] ec, ei;
`ifdef PERF_CNT_EN
    ec = c; ei = i;
`else
    ec = 0; ei = 0;
`endif
    n_assert++;
    assert (cycle_cnt === ec) else begin
      n_fail++;
      $error("FAIL %s cycle_cnt: observed %0d expected %0d", tag, cycle_cnt, ec);
    end
    n_assert++;
    assert (instret_cnt === ei) else begin
      n_fail++;
      $error("FAIL %s instret_cnt: observed %0d expected %0d", tag, instret_cnt, ei);
    end
  endtask
  task automatic rst(input string tag, input logic dr);
    rst_n = 1'b0;
    step({tag, "_r0"}, 1, dr, 1, LD, 0, 1, S_F, O_IDLE);
    cnt({tag, "_rc"}, 0, 0);
    step({tag, "_r1"}, 1, dr, 1, ST, 0, 1, S_F, O_IDLE);
    rst_n = 1'b1;
    cnt({tag, "_rel"}, 0, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    rst("init", 1);
    step("addi_f", 1, 1, 0, OPI, 0, 1, S_F, O_FETR);
    step("addi_d", 1, 1, 0, OPI, 0, 1, S_D, O_IDLE);
    step("addi_e", 1, 1, 0, OPI, 0, 1, S_E, O_IDLE);
    step("addi_w", 1, 1, 0, OPI, 0, 1, S_W, O_WB);
    cnt("addi_cnt", 4, 1);
    step("lw_f", 1, 1, 0, LD, 2, 1, S_F, O_FETR);
    step("lw_d", 1, 1, 0, LD, 2, 1, S_D, O_IDLE);
    step("lw_e", 1, 1, 0, LD, 2, 1, S_E, O_IDLE);
    for (int i = 0; i < 3; i++) step("lw_wait", 1, 0, 0, LD, 2, 1, S_M, O_MEM);
    step("lw_rdy", 1, 1, 0, LD, 2, 1, S_M, O_MEM);
    step("lw_w", 1, 1, 0, LD, 2, 1, S_W, O_WB);
    step("sw_f", 1, 1, 0, ST, 2, 0, S_F, O_FETR);
    step("sw_d", 1, 1, 0, ST, 2, 0, S_D, O_IDLE);
    step("sw_e", 1, 1, 0, ST, 2, 0, S_E, O_IDLE);
    step("sw_m", 1, 1, 0, ST, 2, 0, S_M, O_STR);
    step("beqt_f", 1, 1, 1, BR, 0, 0, S_F, O_FETR);
    step("beqt_d", 1, 1, 1, BR, 0, 0, S_D, O_IDLE);
    step("beqt_e", 1, 1, 1, BR, 0, 0, S_E, O_BRT);
    step("beqn_f", 1, 1, 0, BR, 0, 0, S_F, O_FETR);
    step("beqn_d", 1, 1, 0, BR, 0, 0, S_D, O_IDLE);
    step("beqn_e", 1, 1, 0, BR, 0, 0, S_E, O_BRN);
    step("jalr_f", 1, 1, 0, JALR, 0, 1, S_F, O_FETR);
    step("jalr_d", 1, 1, 0, JALR, 0, 1, S_D, O_IDLE);
    step("jalr_e", 1, 1, 0, JALR, 0, 1, S_E, O_IDLE);
    step("jalr_w", 1, 1, 0, JALR, 0, 1, S_W, O_WBJR);
    step("csr_f", 1, 1, 0, SYS, 1, 1, S_F, O_FETR);
    step("csr_d", 1, 1, 0, SYS, 1, 1, S_D, O_IDLE);
    step("csr_e", 1, 1, 0, SYS, 1, 1, S_E, O_IDLE);
    step("csr_w", 1, 1, 0, SYS, 1, 1, S_W, O_WB);
    cnt("csr_cnt", 30, 7);
    for (int i = 0; i < 3; i++) step("f4_wait", 0, 1, 0, OPI, 0, 1, S_F, O_FET);
    step("f4_rdy", 1, 1, 0, OPI, 0, 1, S_F, O_FETR);
    step("f4_d", 1, 1, 0, OPI, 0, 1, S_D, O_IDLE);
    step("f4_e", 1, 1, 0, OPI, 0, 1, S_E, O_IDLE);
    step("f4_w", 1, 1, 0, OPI, 0, 0, S_W, O_BRN);
    step("jal_f", 1, 1, 0, JAL, 0, 1, S_F, O_FETR);
    step("jal_d", 1, 1, 0, JAL, 0, 1, S_D, O_IDLE);
    step("jal_e", 1, 1, 0, JAL, 0, 1, S_E, O_IDLE);
    step("jal_w", 1, 1, 0, JAL, 0, 1, S_W, O_WBJ);
    cnt("mid_cnt", 41, 9);
    for (int i = 0; i < 4; i++) step("fto_wait", 0, 1, 0, OPI, 0, 1, S_F, O_FET);
    step("fto_flt0", 1, 1, 0, OPI, 0, 1, S_X, O_FLT);
    step("fto_flt1", 1, 1, 0, OPI, 0, 1, S_X, O_FLT);
    rst("ill", 1);
    step("ill_f", 1, 1, 0, BAD, 0, 1, S_F, O_FETR);
    step("ill_d", 1, 1, 0, BAD, 0, 1, S_D, O_IDLE);
    step("ill_flt0", 1, 1, 0, BAD, 0, 1, S_X, O_FLT);
    step("ill_flt1", 1, 1, 0, OPI, 0, 1, S_X, O_FLT);
    rst("ecall", 1);
    step("ecall_f", 1, 1, 0, SYS, 0, 1, S_F, O_FETR);
    step("ecall_d", 1, 1, 0, SYS, 0, 1, S_D, O_IDLE);
    step("ecall_e", 1, 1, 0, SYS, 0, 1, S_E, O_IDLE);
    step("ecall_h0", 1, 1, 0, SYS, 0, 1, S_H, O_HLT);
    step("ecall_h1", 1, 1, 0, SYS, 0, 1, S_H, O_HLT);
    cnt("halt_cnt", 3, 0);
    rst("mto", 1);
    step("mto_f", 1, 1, 0, LD, 2, 1, S_F, O_FETR);
    step("mto_d", 1, 1, 0, LD, 2, 1, S_D, O_IDLE);
    step("mto_e", 1, 1, 0, LD, 2, 1, S_E, O_IDLE);
    for (int i = 0; i < 4; i++) step("mto_wait", 1, 0, 0, LD, 2, 1, S_M, O_MEM);
    step("mto_flt", 1, 1, 0, LD, 2, 1, S_X, O_FLT);
    rst("pre", 1);
    step("mr_f", 1, 1, 0, LD, 2, 1, S_F, O_FETR);
    step("mr_d", 1, 1, 0, LD, 2, 1, S_D, O_IDLE);
    step("mr_e", 1, 1, 0, LD, 2, 1, S_E, O_IDLE);
    step("mr_wait", 1, 0, 0, LD, 2, 1, S_M, O_MEM);
    rst("midmem", 0);
    step("post_rst_f", 0, 0, 0, LD, 2, 1, S_F, O_FET);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
